// File: rtl/videocard_host_bridge_if.sv
// Host-bridge bundle: videocard shared-memory bus, interrupt pair, host memory port and job status.
// The bridge takes the slave view; the videocard and host side together take the master view.
interface videocard_host_bridge_if #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 10
);
    logic [WIDTH-1:0]     gpu_address;
    logic [WIDTH-1:0]     gpu_wdata;
    logic                 gpu_wren;
    logic [WIDTH-1:0]     gpu_rdata;
    logic                 interrupt_start;
    logic                 interrupt_finish;
    logic                 host_req;
    logic                 host_wren;
    logic [ADDR_BITS-1:0] host_addr;
    logic [WIDTH-1:0]     host_wdata;
    logic [WIDTH-1:0]     host_rdata;
    logic                 host_ack;
    logic                 host_kick;
    logic                 busy;
    logic                 done;
    logic                 timeout;

    modport slave (
        input  gpu_address, gpu_wdata, gpu_wren, interrupt_finish,
        input  host_req, host_wren, host_addr, host_wdata, host_kick,
        output gpu_rdata, interrupt_start, host_rdata, host_ack, busy, done, timeout
    );

    modport master (
        output gpu_address, gpu_wdata, gpu_wren, interrupt_finish,
        output host_req, host_wren, host_addr, host_wdata, host_kick,
        input  gpu_rdata, interrupt_start, host_rdata, host_ack, busy, done, timeout
    );
endinterface

// File: rtl/videocard_host_bridge.sv
// Shared memory for the videocard (1-cycle registered reads, no stalls) plus a host req/ack port
// open only in IDLE (ack 1 cycle later, requests outside IDLE wait); kick/finish/timeout job FSM.
module videocard_host_bridge #(
    parameter int WIDTH     = 32,
    parameter int ADDR_BITS = 10,
    parameter int TIMEOUT   = 1023
) (
    input  logic                    clk,
    input  logic                    reset,
    videocard_host_bridge_if.slave  bus
);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_RUN, ST_DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [CNT_W-1:0]     cnt_inc;
    logic                 timeout_q, timeout_d;
    logic                 host_ack_q, host_ack_d;
    logic [WIDTH-1:0]     host_rdata_q, host_rdata_d;
    logic [WIDTH-1:0]     gpu_rdata_q, gpu_rdata_d;
    logic [WIDTH-1:0]     mem_q [2**ADDR_BITS];

    logic                 host_acc;
    logic                 host_we;
    logic                 card_in_range;
    logic                 card_we;
    logic [ADDR_BITS-1:0] card_idx;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cnt_inc       = cnt_q + 1'b1;
        timeout_d     = timeout_q;

        card_in_range = (bus.gpu_address[WIDTH-1:ADDR_BITS] == '0);
        card_idx      = bus.gpu_address[ADDR_BITS-1:0];
        card_we       = bus.gpu_wren && card_in_range;
        gpu_rdata_d   = card_in_range ? mem_q[card_idx] : '0;

        host_acc      = (state_q == ST_IDLE) && bus.host_req;
        host_we       = host_acc && bus.host_wren;
        host_ack_d    = host_acc;
        host_rdata_d  = (host_acc && !bus.host_wren) ? mem_q[bus.host_addr] : host_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.host_kick) begin
                    state_d   = ST_START;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            ST_START: state_d = ST_RUN;
            ST_RUN: begin
                cnt_d = cnt_inc;
                // Finish outranks the abort when both land on the last RUN cycle.
                if (bus.interrupt_finish) begin
                    state_d = ST_DONE;
                end else if (cnt_inc == CNT_W'(TIMEOUT)) begin
                    state_d   = ST_IDLE;
                    timeout_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            host_ack_q   <= 1'b0;
            host_rdata_q <= '0;
            gpu_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            host_ack_q   <= host_ack_d;
            host_rdata_q <= host_rdata_d;
            gpu_rdata_q  <= gpu_rdata_d;
        end
    end

    // Card write is issued last so it wins a same-address collision with the host.
    always_ff @(posedge clk) begin
        if (host_we) mem_q[bus.host_addr] <= bus.host_wdata;
        if (card_we) mem_q[card_idx]      <= bus.gpu_wdata;
    end

    assign bus.gpu_rdata       = gpu_rdata_q;
    assign bus.host_rdata      = host_rdata_q;
    assign bus.host_ack        = host_ack_q;
    assign bus.timeout         = timeout_q;
    assign bus.busy            = (state_q == ST_START) || (state_q == ST_RUN);
    assign bus.interrupt_start = (state_q == ST_START);
    assign bus.done            = (state_q == ST_DONE);
endmodule
